bus_ram_mirror: RTL and testbench
=================================

# bus_ram_mirror

Parametrised bus-slave RAM for the CPU address bus, replacing fixed-size RAM slaves. It decodes a power-of-two address window at a configurable base and mirrors an internal memory of 2^MEM_AW words across that window. It serves single read/write transactions with the Cmd/RW/Finish handshake, and inserts a configurable number of wait states. Memory is inferred in RTL, with no IP core; several instances share one bus, each decoding its own window.

## Interface
- DATA_W, 8, data width in bits
- MEM_AW, 11, memory address bits; depth = 2^MEM_AW words
- WIN_AW, 13, window address bits; window = 2^WIN_AW bytes; MEM_AW <= WIN_AW <= 16
- BASE, 16'h0000, window base; must be aligned, so BASE[WIN_AW-1:0] == 0
- WAIT, 0, extra wait cycles per access, 0..15
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Addr  in  16  bus address
- WData  in  DATA_W  write data
- RData  out  DATA_W  registered read data
- Cmd  in  1  transaction request, level, held by master until Finish
- RW  in  1  1 = write, 0 = read
- Finish  out  1  one-cycle completion pulse
- Hit  out  1  combinational: Addr[15:WIN_AW] == BASE[15:WIN_AW]; 1 for any in-window Addr when WIN_AW = 16

## Operation
- Memory index = Addr[MEM_AW-1:0]. Addr bits WIN_AW-1..MEM_AW are ignored, which mirrors the RAM 2^(WIN_AW-MEM_AW) times.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE: on an edge with Cmd && Hit, latch index, WData and RW.
  - Load wait counter with WAIT.
  - Go to WAIT if WAIT > 0, else go to ACCESS.
  - Cmd && !Hit: stay in IDLE, no response.
- WAIT: decrement the counter each edge. Go to ACCESS on the edge where the counter equals 1.
- ACCESS: one edge.
  - Write: mem[index] <= latched WData.
  - Read: RData <= mem[index].
  - Set Finish <= 1; go to DONE.
- DONE: Finish <= 0; go to IDLE.
- Cmd, Addr, RW and WData are ignored outside IDLE. Inputs changing mid-transaction do not affect it.
- RData holds the last read value until the next read completes. Writes never change RData.
- Memory contents are not reset; power-up contents are undefined.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, Finish = 0, RData = 0, wait counter = 0. All hold while rst_n is low.
- Reset in WAIT or before the ACCESS edge: the transaction is aborted, memory is unchanged and no Finish is produced.
- Let E0 = accepting edge (IDLE, Cmd && Hit).
  - ACCESS edge = E0 + 1 + WAIT.
  - Finish is high for exactly the cycle between E0+1+WAIT and E0+2+WAIT.
- RData is valid at the same edge Finish rises and stays stable afterwards.
- Earliest next acceptance is edge E0+3+WAIT. Back-to-back throughput is one transaction per WAIT+3 cycles.
- If Cmd is still high at the next IDLE edge, a new transaction starts. The master must drop Cmd in the Finish cycle to avoid a repeat.
- Read-after-write to the same index in consecutive transactions returns the newly written data.
- Hit has zero latency and is independent of Cmd and state.

## Test plan
- Reset: assert rst_n low mid-WAIT (WAIT=3), after a write command → Finish stays 0, RData = 0, and a later read of that address returns the prior contents.
- Basic, default parameters: write 8'hA5 @ 16'h0123, then read @ 16'h0123 → Finish one cycle at E0+1 for each; RData = 8'hA5.
- Mirroring, MEM_AW=11, WIN_AW=13: write 8'h3C @ 16'h0007, then read @ 16'h0807, 16'h1007 and 16'h1807 → all return 8'h3C. Read @ 16'h2007 → Hit = 0, no Finish within 20 cycles, RData unchanged.
- Wait states, WAIT=4: read → Finish rises exactly at E0+5. Changing Addr and RW during the WAIT state does not change the result.
- Non-zero base, BASE=16'h6000, WIN_AW=13, MEM_AW=13: Hit = 1 for 16'h6000 and 16'h7FFF, Hit = 0 for 16'h5FFF and 16'h8000. Write and read at 16'h7FFF round-trips 8'h5A.
- Held Cmd: keep Cmd high for 12 cycles with WAIT=0, read → Finish pulses at E0+1, E0+4, E0+7 and E0+10, each one cycle wide. RData never changes on a write.

Source files
------------

// File: rtl/bus_ram_mirror.sv
// bus_ram_mirror: mirrored RAM slave on the CPU address bus.
// Decodes a 2^WIN_AW byte window at BASE; adds WAIT wait states per access.
module bus_ram_mirror #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MEM_AW = 11,
  parameter int unsigned WIN_AW = 13,
  parameter logic [15:0] BASE   = 16'h0000,
  parameter int unsigned WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       Addr,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] RData,
  input  logic              Cmd,
  input  logic              RW,
  output logic              Finish,
  output logic              Hit
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] WAIT_LD  = 4'(WAIT);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] idx;
  logic [DATA_W-1:0] wdata_q;
  logic              rw_q;
  logic              accept;
  logic              unused_addr;

  logic [DATA_W-1:0] mem [2**MEM_AW];

  // A full 64K window matches every address.
  generate
    if (WIN_AW >= 16) begin : g_full
      assign Hit = 1'b1;
    end else begin : g_win
      assign Hit = (Addr[15:WIN_AW] == BASE[15:WIN_AW]);
    end
  endgenerate

  // Window bits above the RAM index are don't-care: that is the mirroring.
  assign unused_addr = ^Addr;

  assign accept = (state == S_IDLE) && Cmd && Hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      RData   <= '0;
      Finish  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            idx     <= Addr[MEM_AW-1:0];
            wdata_q <= WData;
            rw_q    <= RW;
            cnt     <= WAIT_LD;
            state   <= (WAIT_LD != 4'd0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!rw_q)
            RData <= mem[idx];
          Finish <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          Finish <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && rw_q)
      mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_bus_ram_mirror.sv
// tb_bus_ram_mirror: three RAM slaves on one shared bus plus a full-window
// decoder, checked against an array-based model of the address map.
module tb_bus_ram_mirror;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        cmd = 1'b0;
  logic        rw = 1'b0;

  logic [7:0] rd_a, rd_b, rd_c, rd_d;
  logic       fin_a, fin_b, fin_c, fin_d;
  logic       hit_a, hit_b, hit_c, hit_d;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bus_ram_mirror #(.DATA_W(8), .MEM_AW(11), .WIN_AW(13),
    .BASE(16'h0000), .WAIT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .Addr(addr), .WData(wdata),
    .RData(rd_a), .Cmd(cmd), .RW(rw), .Finish(fin_a), .Hit(hit_a));

  bus_ram_mirror #(.DATA_W(8), .MEM_AW(13), .WIN_AW(13),
    .BASE(16'h6000), .WAIT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .Addr(addr), .WData(wdata),
    .RData(rd_b), .Cmd(cmd), .RW(rw), .Finish(fin_b), .Hit(hit_b));

  bus_ram_mirror #(.DATA_W(8), .MEM_AW(10), .WIN_AW(12),
    .BASE(16'hA000), .WAIT(3)) u_c (
    .clk(clk), .rst_n(rst_n), .Addr(addr), .WData(wdata),
    .RData(rd_c), .Cmd(cmd), .RW(rw), .Finish(fin_c), .Hit(hit_c));

  bus_ram_mirror #(.DATA_W(8), .MEM_AW(4), .WIN_AW(16),
    .BASE(16'h0000), .WAIT(0)) u_d (
    .clk(clk), .rst_n(rst_n), .Addr(addr), .WData(wdata),
    .RData(rd_d), .Cmd(1'b0), .RW(rw), .Finish(fin_d), .Hit(hit_d));

  localparam int NI = 3;
  int depth [NI] = '{2048, 8192, 1024};
  int wsz   [NI] = '{8192, 8192, 4096};
  int base  [NI] = '{'h0000, 'h6000, 'hA000};
  int wts   [NI] = '{0, 4, 3};

  logic [7:0] mdl     [NI][8192];
  bit         known   [NI][8192];
  logic [7:0] last_rd [NI];
  int         widx    [NI][$];

  typedef struct {
    logic [15:0] a;
    logic [3:0]  h;
  } hit_vec_t;

  hit_vec_t hv [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] rdv(input int s);
    case (s)
      0:       return rd_a;
      1:       return rd_b;
      default: return rd_c;
    endcase
  endfunction

  task automatic xact(input int s, input bit w, input logic [15:0] a,
                      input logic [7:0] d, input bit scr,
                      input string nm);
    logic [31:0] seen;
    logic [2:0]  f;
    logic [7:0]  got;
    logic [7:0]  e;
    int          i;
    seen = '0;
    got = '0;
    i = int'(a) % depth[s];
    addr = a; rw = w; wdata = d; cmd = 1'b1;
    step();
    for (int k = 1; k <= wts[s] + 3; k++) begin
      if (scr && k <= wts[s]) begin
        addr  = 16'(base[s] + int'($urandom_range(0, wsz[s] - 1)));
        rw    = 1'($urandom_range(0, 1));
        wdata = 8'($urandom);
      end
      step();
      f = {fin_c, fin_b, fin_a};
      if (f[s]) seen[k] = 1'b1;
      if ((f & ~(3'b001 << s)) != 3'b000) seen[31] = 1'b1;
      if (k == wts[s] + 1) begin
        cmd = 1'b0;
        got = rdv(s);
      end
    end
    if (w) begin
      if (!known[s][i]) widx[s].push_back(i);
      mdl[s][i] = d;
      known[s][i] = 1'b1;
      e = last_rd[s];
    end else begin
      e = mdl[s][i];
      last_rd[s] = e;
    end
    chk({nm, " finish"}, seen, 32'd1 << (wts[s] + 1));
    chk({nm, " rdata"}, {24'd0, got}, {24'd0, e});
  endtask

  initial begin
    logic [31:0] seen;
    bit          any;

    hv[0]  = '{16'h0000, 4'b1001};
    hv[1]  = '{16'h0123, 4'b1001};
    hv[2]  = '{16'h1FFF, 4'b1001};
    hv[3]  = '{16'h2000, 4'b1000};
    hv[4]  = '{16'h2007, 4'b1000};
    hv[5]  = '{16'h5FFF, 4'b1000};
    hv[6]  = '{16'h6000, 4'b1010};
    hv[7]  = '{16'h7FFF, 4'b1010};
    hv[8]  = '{16'h8000, 4'b1000};
    hv[9]  = '{16'hA000, 4'b1100};
    hv[10] = '{16'hAFFF, 4'b1100};
    hv[11] = '{16'hB000, 4'b1000};
    hv[12] = '{16'hFFFF, 4'b1000};

    for (int s = 0; s < NI; s++) last_rd[s] = 8'h00;

    repeat (3) step();
    chk("reset finish", {29'd0, fin_c, fin_b, fin_a}, 32'd0);
    chk("reset rdata", {8'd0, rd_c, rd_b, rd_a}, 32'd0);
    rst_n = 1'b1;
    step();

    foreach (hv[n]) begin
      addr = hv[n].a;
      #1;
      chk($sformatf("hit %h", hv[n].a),
          {28'd0, hit_d, hit_c, hit_b, hit_a}, {28'd0, hv[n].h});
    end
    step();

    xact(0, 1'b1, 16'h0123, 8'hA5, 1'b0, "basic wr");
    xact(0, 1'b0, 16'h0123, 8'h00, 1'b0, "basic rd");

    xact(0, 1'b1, 16'h0007, 8'h3C, 1'b0, "mirror wr");
    xact(0, 1'b0, 16'h0807, 8'h00, 1'b0, "mirror 0807");
    xact(0, 1'b0, 16'h1007, 8'h00, 1'b0, "mirror 1007");
    xact(0, 1'b0, 16'h1807, 8'h00, 1'b0, "mirror 1807");

    addr = 16'h2007; rw = 1'b0; cmd = 1'b1;
    any = 1'b0;
    repeat (20) begin
      step();
      if (fin_a || fin_b || fin_c) any = 1'b1;
    end
    cmd = 1'b0;
    chk("miss finish", {31'd0, any}, 32'd0);
    chk("miss rdata", {24'd0, rd_a}, {24'd0, last_rd[0]});
    step();

    xact(1, 1'b1, 16'h7FFF, 8'h5A, 1'b0, "base wr 7fff");
    xact(1, 1'b0, 16'h7FFF, 8'h00, 1'b1, "wait rd 7fff");
    xact(1, 1'b1, 16'h6000, 8'hC3, 1'b1, "wait wr 6000");
    xact(1, 1'b0, 16'h6000, 8'h00, 1'b0, "base rd 6000");

    addr = 16'h0123; rw = 1'b0; cmd = 1'b1;
    step();
    seen = '0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (fin_a) seen[k] = 1'b1;
      if (fin_b || fin_c) seen[31] = 1'b1;
      if (k == 11) cmd = 1'b0;
    end
    chk("held cmd finish", seen, 32'h0000_0492);
    chk("held cmd rdata", {24'd0, rd_a}, 32'h0000_00A5);
    last_rd[0] = 8'hA5;

    xact(2, 1'b1, 16'hA055, 8'h11, 1'b0, "rst prep wr");
    xact(2, 1'b0, 16'hA055, 8'h00, 1'b0, "rst prep rd");
    addr = 16'hA055; rw = 1'b1; wdata = 8'h99; cmd = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("async rst rdata", {8'd0, rd_c, rd_b, rd_a}, 32'd0);
    cmd = 1'b0;
    any = 1'b0;
    repeat (6) begin
      step();
      if (fin_a || fin_b || fin_c || rd_c != 8'h00) any = 1'b1;
    end
    chk("rst hold", {31'd0, any}, 32'd0);
    #2 rst_n = 1'b1;
    for (int s = 0; s < NI; s++) last_rd[s] = 8'h00;
    step();
    any = 1'b0;
    repeat (6) begin
      step();
      if (fin_c) any = 1'b1;
    end
    chk("abort no finish", {31'd0, any}, 32'd0);
    xact(2, 1'b0, 16'hA055, 8'h00, 1'b0, "rst aborted wr");
    xact(2, 1'b0, 16'hA455, 8'h00, 1'b1, "rst mirror rd");

    for (int n = 0; n < 60; n++) begin
      int          s;
      int          i;
      bit          w;
      logic [15:0] a;
      s = int'($urandom_range(0, NI - 1));
      w = ($urandom_range(0, 1) == 1) || (widx[s].size() == 0);
      if (w) begin
        a = 16'(base[s] + int'($urandom_range(0, wsz[s] - 1)));
      end else begin
        i = widx[s][$urandom_range(0, widx[s].size() - 1)];
        a = 16'(base[s] + i + depth[s] *
            int'($urandom_range(0, wsz[s] / depth[s] - 1)));
      end
      xact(s, w, a, 8'($urandom), 1'($urandom_range(0, 1)),
           $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
